// File: rtl/aes_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_core_pkg
// Purpose  : Shared types and constants for the AES multi-channel front end:
//            block width, per-request mode encoding, arbiter FSM states and
//            a helper that sizes channel-index fields.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package aes_core_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef enum logic {
        AES_ENC = 1'b0,
        AES_DEC = 1'b1
    } aes_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } aes_arb_state_e;

    // A single channel still needs a 1-bit index field.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_rr_arbiter
// Purpose  : Purely combinational round-robin selector. Grants the first
//            requesting channel at or after the pointer, wrapping around.
// Ports    : i_req       [NUM_CH-1:0] request vector
//            i_ptr       [CH_W-1:0]   highest-priority channel
//            o_gnt       [NUM_CH-1:0] one-hot grant (zero when no request)
//            o_gnt_idx   [CH_W-1:0]   index of granted channel
//            o_gnt_valid              any request present
// Revision : 1.0 - initial release
// ============================================================================
module aes_rr_arbiter
    import aes_core_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]           i_req,
    input  logic [ch_width(NUM_CH)-1:0] i_ptr,
    output logic [NUM_CH-1:0]           o_gnt,
    output logic [ch_width(NUM_CH)-1:0] o_gnt_idx,
    output logic                        o_gnt_valid
);

    localparam int c_CH_W = ch_width(NUM_CH);

    int w_dist;
    int w_best;

    // Each requester's distance from the pointer (mod NUM_CH) is its
    // priority; the smallest distance wins.
    always_comb begin
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        w_best      = NUM_CH;
        w_dist      = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            w_dist = j - int'(i_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_CH;
            end
            if (i_req[j] && (w_dist < w_best)) begin
                w_best      = w_dist;
                o_gnt_idx   = c_CH_W'(j);
                o_gnt_valid = 1'b1;
            end
        end
    end

    always_comb begin
        o_gnt = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            o_gnt[j] = o_gnt_valid && (o_gnt_idx == c_CH_W'(j));
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_core_arb.sv
`default_nettype none
// ============================================================================
// Module   : aes_core_arb
// Purpose  : Multi-channel front end for a shared AES engine. Arbitrates
//            NUM_CH valid/ready request channels round-robin, issues one
//            block at a time with a per-request encrypt/decrypt mode, and
//            returns result, channel tag and mode on a valid/ready output.
//            A watchdog completes a job with m_err=1 if the engine stalls.
// Ports    : clk, rst_n                  clock, async active-low reset
//            s_valid/s_ready/s_mode      per-channel request handshake, mode
//            s_data/s_key                per-channel block and key (packed)
//            eng_start/eng_mode          one-cycle job start, job mode
//            eng_data/eng_key            job operands, held during the job
//            eng_done/eng_result         engine completion and result
//            m_valid/m_ready             result handshake
//            m_data/m_ch/m_mode/m_err    result, source channel, mode, timeout
//            busy                        FSM not idle
// Revision : 1.0 - initial release
// ============================================================================
module aes_core_arb
    import aes_core_pkg::*;
#(
    parameter int DATA_W  = AES_BLOCK_W,
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           s_valid,
    output logic [NUM_CH-1:0]           s_ready,
    input  logic [NUM_CH-1:0]           s_mode,
    input  logic [NUM_CH*DATA_W-1:0]    s_data,
    input  logic [NUM_CH*DATA_W-1:0]    s_key,
    output logic                        eng_start,
    output logic                        eng_mode,
    output logic [DATA_W-1:0]           eng_data,
    output logic [DATA_W-1:0]           eng_key,
    input  logic                        eng_done,
    input  logic [DATA_W-1:0]           eng_result,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_W-1:0]           m_data,
    output logic [ch_width(NUM_CH)-1:0] m_ch,
    output logic                        m_mode,
    output logic                        m_err,
    output logic                        busy
);

    localparam int c_CH_W  = ch_width(NUM_CH);
    localparam int c_TMR_W = $clog2(TIMEOUT + 1);

    aes_arb_state_e      r_state;
    logic [c_CH_W-1:0]   r_ptr;
    logic [c_CH_W-1:0]   r_ch;
    logic                r_mode;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_key;
    logic [c_TMR_W-1:0]  r_timer;
    logic                r_eng_start;
    logic                r_m_valid;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_m_err;

    logic [NUM_CH-1:0]   w_gnt;
    logic [c_CH_W-1:0]   w_gnt_idx;
    logic                w_gnt_valid;
    logic [DATA_W-1:0]   w_sel_data;
    logic [DATA_W-1:0]   w_sel_key;
    logic                w_sel_mode;

    aes_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req       (s_valid),
        .i_ptr       (r_ptr),
        .o_gnt       (w_gnt),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_valid (w_gnt_valid)
    );

    // Operand mux for the granted channel.
    always_comb begin
        w_sel_data = '0;
        w_sel_key  = '0;
        w_sel_mode = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (w_gnt_idx == c_CH_W'(j)) begin
                w_sel_data = s_data[j*DATA_W +: DATA_W];
                w_sel_key  = s_key[j*DATA_W +: DATA_W];
                w_sel_mode = s_mode[j];
            end
        end
    end

    // s_ready is combinational so a request is accepted in the same cycle it
    // is seen in IDLE; it is forced low while reset is asserted so every
    // output reads zero under reset.
    assign s_ready = (rst_n && (r_state == IDLE)) ? w_gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_ch        <= '0;
            r_mode      <= 1'b0;
            r_data      <= '0;
            r_key       <= '0;
            r_timer     <= '0;
            r_eng_start <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_err     <= 1'b0;
        end else begin
            r_eng_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_ch        <= w_gnt_idx;
                        r_mode      <= w_sel_mode;
                        r_data      <= w_sel_data;
                        r_key       <= w_sel_key;
                        // Registered so the pulse lines up with ISSUE.
                        r_eng_start <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_timer <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Done is checked first so a completion in the last
                    // allowed cycle beats the watchdog.
                    if (eng_done) begin
                        r_m_data  <= eng_result;
                        r_m_err   <= 1'b0;
                        r_m_valid <= 1'b1;
                        r_state   <= OUT;
                    end else if (r_timer == c_TMR_W'(TIMEOUT - 1)) begin
                        r_m_data  <= '0;
                        r_m_err   <= 1'b1;
                        r_m_valid <= 1'b1;
                        r_state   <= OUT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        if (r_ch == c_CH_W'(NUM_CH - 1)) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= r_ch + 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign eng_start = r_eng_start;
    assign eng_mode  = r_mode;
    assign eng_data  = r_data;
    assign eng_key   = r_key;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_ch      = r_ch;
    assign m_mode    = r_mode;
    assign m_err     = r_m_err;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
